mdu_pipe: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers, for the EX stage of the 5-stage pipeline.
- Successor to the fixed single-cycle ALU path: configurable data width and per-operation latency.
- Exposes `busy` so the hazard unit stalls later MDU-dependent instructions in ID.
- Writes to HI/LO from the ID/EX register path happen at the edge, with no latency.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_if.sv | 17 +
 rtl/mdu_arith.sv | 71 +++++++
 rtl/mdu_pipe.sv | 86 ++++++++
 tb/tb_mdu_pipe.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM state constants and default latencies for the MDU
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MAC   = 3'd7
  } mdu_op_e;

  // OP_MAC sub-field: bit0 selects unsigned product, bit1 selects subtract
  localparam logic [1:0] MAC_MADD  = 2'd0;
  localparam logic [1:0] MAC_MADDU = 2'd1;
  localparam logic [1:0] MAC_MSUB  = 2'd2;
  localparam logic [1:0] MAC_MSUBU = 2'd3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - EX-stage request / HI-LO result bundle between pipeline and MDU
interface mdu_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             start;
  mdu_op_e          op;
  logic [1:0]       sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, sub, a, b, kill, input busy, hi, lo);
  modport slave  (input start, op, sub, a, b, kill, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational HI/LO result for every MDU op (MAC ops only with MDU_MADD_EN)
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  mdu_op_e          op,
  input  logic [1:0]       sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             div_zero
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [W2-1:0]    sprod, uprod;
  logic [WIDTH-1:0] mag_a, mag_b, dvs_u, dvs_s;
  logic [WIDTH-1:0] uq, ur, mq, mr, sq, sr;
  logic             neg_a, neg_b;
`ifdef MDU_MADD_EN
  logic [W2-1:0]    prod, mac;
`else
  logic             unused_sub;
  assign unused_sub = ^sub;
`endif

  always_comb begin
    neg_a = a[WIDTH-1];
    neg_b = b[WIDTH-1];
    sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    div_zero = ((op == OP_DIV) || (op == OP_DIVU)) && (b == '0);

    // Signed divide works on magnitudes; most-negative / -1 falls out naturally
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
    dvs_u = (b == '0) ? ONE : b;
    dvs_s = (mag_b == '0) ? ONE : mag_b;
    uq = a / dvs_u;
    ur = a % dvs_u;
    mq = mag_a / dvs_s;
    mr = mag_a % dvs_s;
    sq = (neg_a ^ neg_b) ? -mq : mq;
    sr = neg_a ? -mr : mr;

    next_hi = hi;
    next_lo = lo;
`ifdef MDU_MADD_EN
    prod = sub[0] ? uprod : sprod;
    mac  = sub[1] ? ({hi, lo} - prod) : ({hi, lo} + prod);
`endif
    case (op)
      OP_MULT:  {next_hi, next_lo} = sprod;
      OP_MULTU: {next_hi, next_lo} = uprod;
      OP_DIV:   if (!div_zero) {next_hi, next_lo} = {sr, sq};
      OP_DIVU:  if (!div_zero) {next_hi, next_lo} = {ur, uq};
      OP_MTHI:  next_hi = a;
      OP_MTLO:  next_lo = a;
`ifdef MDU_MADD_EN
      OP_MAC:   {next_hi, next_lo} = mac;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_pipe.sv
// rtl/mdu_pipe.sv - multi-cycle mult/div unit with HI/LO; MDU_MADD_EN adds madd/maddu/msub/msubu
module mdu_pipe
  import mdu_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave m
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic             state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_q, lo_q, shadow_hi, shadow_lo;
  logic             shadow_dz;
  logic [WIDTH-1:0] next_hi, next_lo;
  logic             div_zero;
  logic             is_div, is_long, is_move;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op       (m.op),
    .sub      (m.sub),
    .a        (m.a),
    .b        (m.b),
    .hi       (hi_q),
    .lo       (lo_q),
    .next_hi  (next_hi),
    .next_lo  (next_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    is_div  = (m.op == OP_DIV) || (m.op == OP_DIVU);
    is_long = is_div || (m.op == OP_MULT) || (m.op == OP_MULTU);
`ifdef MDU_MADD_EN
    if (m.op == OP_MAC) is_long = 1'b1;
`endif
    is_move = (m.op == OP_MTHI) || (m.op == OP_MTLO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      shadow_dz <= 1'b0;
    end else if (state == ST_RUN) begin
      if (m.kill) begin
        state <= ST_IDLE;
      end else if (count == '0) begin
        state <= ST_IDLE;
        if (!shadow_dz) begin
          hi_q <= shadow_hi;
          lo_q <= shadow_lo;
        end
      end else begin
        count <= count - 1'b1;
      end
    end else if (m.start && !m.kill) begin
      // A flush in the same cycle drops the request outright
      if (is_long) begin
        shadow_hi <= next_hi;
        shadow_lo <= next_lo;
        shadow_dz <= div_zero;
        count     <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        state     <= ST_RUN;
      end else if (is_move) begin
        hi_q <= next_hi;
        lo_q <= next_lo;
      end
    end
  end

  assign m.busy = (state == ST_RUN);
  assign m.hi   = hi_q;
  assign m.lo   = lo_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// tb/tb_mdu_pipe.sv - directed vector table plus reset/kill/back-to-back sequences for mdu_pipe
module tb_mdu_pipe;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  mdu_if #(.WIDTH(32)) bus ();

  mdu_pipe #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .m     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    mdu_op_e     op;
    logic [1:0]  sub;
    logic [31:0] a, b, pre_hi, pre_lo;
    int          cyc;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input mdu_op_e op, input logic [1:0] sub, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ph, input logic [31:0] pl, input int cyc,
                     input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = op; v.sub = sub; v.a = a; v.b = b; v.pre_hi = ph; v.pre_lo = pl;
    v.cyc = cyc; v.hi = hi; v.lo = lo;
    vecs.push_back(v);
  endtask

  // Returns at the falling edge just after the accepting edge
  task automatic issue(input mdu_op_e op, input logic [1:0] sub, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.sub = sub; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    issue(OP_MTHI, 2'd0, h, 32'd0);
    issue(OP_MTLO, 2'd0, l, 32'd0);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = OP_NOP; bus.sub = 2'd0;
    bus.a = '0; bus.b = '0; bus.kill = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;

    add(OP_MULT,  0, 32'hFFFFFFFF, 32'd2, 0, 0, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    add(OP_MULTU, 0, 32'hFFFFFFFF, 32'd2, 0, 0, 5, 32'h00000001, 32'hFFFFFFFE);
    add(OP_MULT,  0, 32'd7, 32'd6, 9, 9, 5, 32'h0, 32'h2A);
    add(OP_MULTU, 0, 32'h10000, 32'h10000, 0, 0, 5, 32'h1, 32'h0);
    add(OP_MULT,  0, 32'h80000000, 32'h80000000, 0, 0, 5, 32'h40000000, 32'h0);
    add(OP_DIV,   0, 32'hFFFFFFF9, 32'd2, 0, 0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    add(OP_DIV,   0, 32'h80000000, 32'hFFFFFFFF, 7, 7, 10, 32'h0, 32'h80000000);
    add(OP_DIV,   0, 32'd7, 32'hFFFFFFFE, 0, 0, 10, 32'h1, 32'hFFFFFFFD);
    add(OP_DIVU,  0, 32'd100, 32'd7, 0, 0, 10, 32'h2, 32'hE);
    add(OP_DIVU,  0, 32'd99, 32'd0, 32'h1234, 32'h5678, 10, 32'h1234, 32'h5678);
    add(OP_DIV,   0, 32'd5, 32'd0, 32'hAAAA, 32'hBBBB, 10, 32'hAAAA, 32'hBBBB);
    add(OP_NOP,   0, 32'd3, 32'd3, 32'h21, 32'h43, 0, 32'h21, 32'h43);
`ifdef MDU_MADD_EN
    add(OP_MAC, MAC_MADD,  32'd3, 32'd4, 32'd0, 32'd5, 5, 32'h0, 32'd17);
    add(OP_MAC, MAC_MSUBU, 32'd1, 32'd18, 32'd0, 32'd17, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    add(OP_MAC, MAC_MSUB,  32'hFFFFFFFF, 32'd2, 32'd0, 32'd1, 5, 32'h0, 32'd3);
`else
    add(OP_MAC, MAC_MADD,  32'd3, 32'd4, 32'd0, 32'd5, 0, 32'h0, 32'd5);
`endif

    foreach (vecs[i]) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].sub, vecs[i].a, vecs[i].b);
      wait_idle(cyc);
      check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
    end

    // mthi: no busy, hi visible right after the accepting edge
    issue(OP_MTHI, 2'd0, 32'hCAFE, 32'd0);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check("mthi_hi", 64'(bus.hi), 64'hCAFE);

    // Asynchronous reset in the middle of a mult
    set_hilo(32'h11, 32'h22);
    issue(OP_MULT, 2'd0, 32'd7, 32'd6);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_after_busy", 64'(bus.busy), 64'd0);
    check("rst_after_hilo", {bus.hi, bus.lo}, 64'd0);

    // kill in cycle 3 of divu, with a simultaneous start that must be dropped
    set_hilo(32'h55, 32'h66);
    issue(OP_DIVU, 2'd0, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    bus.kill = 1'b1; bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.kill = 1'b0; bus.start = 1'b0; bus.op = OP_NOP;
    check("kill_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("kill_start_dropped", 64'(bus.busy), 64'd0);
    repeat (12) @(negedge clk);
    check("kill_hilo", {bus.hi, bus.lo}, {32'h55, 32'h66});

    // start held across the completion edge: taken one edge later
    issue(OP_MULT, 2'd0, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    check("b2b_last_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    check("b2b_done_busy", 64'(bus.busy), 64'd0);
    check("b2b_first_hilo", {bus.hi, bus.lo}, {32'h0, 32'hF});
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
    wait_idle(cyc);
    check("b2b_second_cycles", 64'(cyc), 64'd5);
    check("b2b_second_hilo", {bus.hi, bus.lo}, {32'h0, 32'h4});

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
